relm_fp_normalize: RTL
======================

RELM_FP_NORMALIZE -- requirements
Module: relm_fp_normalize

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset, with ports clk and rst_n.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  async active-low reset.
REQ-004 SHALL have port: in_valid  input  1  raw FP result offered.
REQ-005 SHALL have port: in_ready  output  1  block can accept a raw result.
REQ-006 SHALL have port: mant_in  input  32  raw mantissa; hidden one nominally at bit 30, overflow at bit 31, guard/sticky in bits 6:0.
REQ-007 SHALL have port: info_in  input  32  descriptor: [31] sign, [30:23] biased exp, [22] inf flag, [21] zero flag; [20:0] ignored.
REQ-008 SHALL have port: out_valid  output  1  packed result available.
REQ-009 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-010 SHALL have port: result_out  output  32  IEEE-754 single result.
REQ-011 SHALL have parameter: WD, default 32, datapath width; only 32 supported.

Function
REQ-012 SHALL implement FSM states IDLE, NORM, ROUND, DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE; accept occurs on a clock edge with in_valid&in_ready.
REQ-014 SHALL, on accept, register mant_in into m[31:0], sign, and exp as 10-bit signed e={2'b00,info_in[30:23]}, register inf/zero flags, then enter NORM.
REQ-015 SHALL, when inf or zero flag is set, skip normalisation: NORM goes directly to ROUND, and ROUND produces the special result.
REQ-016 SHALL apply the following in NORM, evaluated in priority order each cycle:
  (a) m[31]=1: m = m>>1 with bit0 = m[1]|m[0] (sticky), e = e+1, goto ROUND.
  (b) m=0: goto ROUND (zero result).
  (c) m[30]=1: goto ROUND.
  (d) m[30:23]=0: m = m<<8, e = e-8, stay in NORM.
  (e) otherwise: m = m<<1, e = e-1, stay in NORM.
REQ-017 SHALL, in ROUND, round to nearest even: lsb=m[7], g=m[6], s=|m[5:0], up=g&(s|lsb); f[23:0] = m[30:7] + up; if f overflows to 25 bits, frac=0 and e=e+1, else frac=f[22:0].
REQ-018 SHALL form result_out in ROUND and register it with the following precedence:
  - inf&zero flags: {sign, 8'hFF, 23'h400000} (NaN).
  - inf flag, or e>=255: {sign, 8'hFF, 23'd0}.
  - zero flag, m=0, or e<=0: {sign, 31'd0} (flush-to-zero, no denormals).
  - otherwise: {sign, e[7:0], frac}.
  ROUND then goes to DONE.
REQ-019 SHALL assert out_valid only in DONE, holding result_out stable until out_valid&out_ready, then return to IDLE.
REQ-020 SHALL produce out_valid 3 cycles after the accept edge when no left shift is needed; each shift cycle of REQ-016(d)/(e) adds 1 cycle; worst case is 9 NORM cycles.
REQ-021 SHALL NOT accept new input in the same cycle that the DONE handshake completes; no pipelining (single outstanding operation).
REQ-022 SHALL ignore in_valid outside IDLE, and SHALL ignore out_ready outside DONE.
REQ-023 SHALL compute e in 10-bit two's complement; intermediate negative values are legal and only the REQ-018 checks decide the outcome.

Reset
REQ-024 SHALL, on rst_n low (asynchronously, at any state including mid-NORM), set state=IDLE, in_ready=1, out_valid=0, result_out=0, m=0, e=0, and all flags to 0.
REQ-025 SHALL discard any in-flight operation on reset; the first accept after rst_n rises behaves as if from power-up.

Verification
REQ-026 SHALL verify: mant_in=0x40000000, info_in=0x3F800000 -> result_out=0x3F800000, out_valid at accept+3.
REQ-027 SHALL verify: mant_in=0x80000000, exp 127 -> 0x40000000; exp 254 -> 0x7F800000 (overflow to inf).
REQ-028 SHALL verify: mant_in=0x00400000, exp 127 -> 0x3B800000, out_valid at accept+4 (one shift-by-8); mant_in=0 -> 0x00000000.
REQ-029 SHALL verify: mant_in=0x400000C0 -> 0x3F800002; mant_in=0x40000040 (tie, even) -> 0x3F800000; mant_in=0x7FFFFFC0 -> 0x40000000 (carry).
REQ-030 SHALL verify: info_in=0xBF800000|inf|zero -> 0xFFC00000; inf only -> 0xFF800000; out_ready held low 5 cycles -> result_out stable and in_ready=0 throughout.
REQ-031 SHALL verify: rst_n pulsed low during a NORM cycle -> out_valid=0, in_ready=1 immediately (async), and the next operation completes correctly.

Source files
------------

// File: rtl/relm_fp_normalize.sv
// Normalises, rounds (nearest-even) and packs one raw FP result into IEEE-754 single; one operation in flight.
// Latency accept+3 cycles plus one per left-shift step; in_ready only when idle, result held until out_ready.
module relm_fp_normalize #(
  parameter int WD = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [WD-1:0] mant_in,
  input  logic [WD-1:0] info_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WD-1:0] result_out
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t             state_q, state_d;
  logic [31:0]        m_q, m_d;
  logic signed [9:0]  e_q, e_d;
  logic               sign_q, sign_d;
  logic               inf_q, inf_d;
  logic               zero_q, zero_d;
  logic [31:0]        res_q, res_d;

  logic               rnd_lsb, rnd_g, rnd_s, rnd_up;
  logic [24:0]        rnd_f;
  logic [22:0]        rnd_frac;
  logic signed [9:0]  rnd_e;
  logic [31:0]        packed_res;
  logic               unused_bits;

  // Round-to-nearest-even on the normalised mantissa; a carry out renormalises by bumping e.
  always_comb begin
    rnd_lsb = m_q[7];
    rnd_g   = m_q[6];
    rnd_s   = |m_q[5:0];
    rnd_up  = rnd_g & (rnd_s | rnd_lsb);
    rnd_f   = {1'b0, m_q[30:7]} + {24'd0, rnd_up};
    if (rnd_f[24]) begin
      rnd_frac = '0;
      rnd_e    = e_q + 10'sd1;
    end else begin
      rnd_frac = rnd_f[22:0];
      rnd_e    = e_q;
    end

    if (inf_q && zero_q) begin
      packed_res = {sign_q, 8'hFF, 23'h400000};
    end else if (inf_q || (rnd_e >= 10'sd255)) begin
      packed_res = {sign_q, 8'hFF, 23'd0};
    end else if (zero_q || (m_q == '0) || (rnd_e <= 10'sd0)) begin
      packed_res = {sign_q, 31'd0};
    end else begin
      packed_res = {sign_q, rnd_e[7:0], rnd_frac};
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    e_d       = e_q;
    sign_d    = sign_q;
    inf_d     = inf_q;
    zero_d    = zero_q;
    res_d     = res_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          m_d     = mant_in;
          sign_d  = info_in[31];
          e_d     = signed'({2'b00, info_in[30:23]});
          inf_d   = info_in[22];
          zero_d  = info_in[21];
          state_d = NORM;
        end
      end

      NORM: begin
        if (inf_q || zero_q) begin
          state_d = ROUND;
        end else if (m_q[31]) begin
          // Mantissa overflow: shift right once, folding the dropped bit into sticky.
          m_d     = {1'b0, m_q[31:2], m_q[1] | m_q[0]};
          e_d     = e_q + 10'sd1;
          state_d = ROUND;
        end else if (m_q == '0) begin
          state_d = ROUND;
        end else if (m_q[30]) begin
          state_d = ROUND;
        end else if (m_q[30:23] == 8'd0) begin
          m_d = {m_q[23:0], 8'd0};
          e_d = e_q - 10'sd8;
        end else begin
          m_d = {m_q[30:0], 1'b0};
          e_d = e_q - 10'sd1;
        end
      end

      ROUND: begin
        res_d   = packed_res;
        e_d     = rnd_e;
        state_d = DONE;
      end

      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      m_q     <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      inf_q   <= inf_d;
      zero_q  <= zero_d;
      res_q   <= res_d;
    end
  end

  assign result_out  = res_q;
  assign unused_bits = ^{rnd_f[23], info_in[20:0]};

endmodule
